// File: rtl/spi_slave_regbank_pkg.sv
// Shared types and constants for the SPI register-bank responder.
// Imported by the PHY and the top level.
package spi_slave_regbank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  localparam int BYTE_W     = 8;
  localparam int CMD_RW_BIT = 7;
  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/spi_slave_regbank_phy.sv
// SPI mode-0 bit layer: input sync, edge detect, bit counter,
// RX shifter and MISO shifter with start/preload controls.
module spi_slave_regbank_phy
  import spi_slave_regbank_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_sclk_i,
  input  logic              spi_cs_i,
  input  logic              spi_mosi_i,
  input  logic              tx_start,
  input  logic              tx_load,
  input  logic [BYTE_W-1:0] tx_byte,
  output logic              byte_done,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              cs_fall,
  output logic              cs_rise,
  output logic              cs_sync,
  output logic              miso
);

  logic [SYNC_DEPTH-1:0] sclk_sy;
  logic [SYNC_DEPTH-1:0] cs_sy;
  logic [SYNC_DEPTH-1:0] mosi_sy;
  logic                  sclk_d;
  logic                  cs_d;
  logic                  sclk_s;
  logic                  mosi_s;
  logic                  sclk_rise;
  logic                  sclk_fall;
  logic                  active;
  logic [2:0]            bit_cnt;
  logic [BYTE_W-1:0]     rx_q;
  logic [BYTE_W-1:0]     tx_q;
  logic                  miso_q;

  assign sclk_s    = sclk_sy[SYNC_DEPTH-1];
  assign cs_sync   = cs_sy[SYNC_DEPTH-1];
  assign mosi_s    = mosi_sy[SYNC_DEPTH-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_sync & cs_d;
  assign cs_rise   = cs_sync & ~cs_d;
  assign active    = ~cs_sync;

  assign rx_byte   = {rx_q[BYTE_W-2:0], mosi_s};
  assign byte_done = sclk_rise & active & (bit_cnt == 3'd7);
  assign miso      = miso_q;

  // CS resets low so a CS held low across reset gives no falling edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_sy <= '0;
      cs_sy   <= '0;
      mosi_sy <= '0;
      sclk_d  <= 1'b0;
      cs_d    <= 1'b0;
    end else begin
      sclk_sy <= {sclk_sy[SYNC_DEPTH-2:0], spi_sclk_i};
      cs_sy   <= {cs_sy[SYNC_DEPTH-2:0], spi_cs_i};
      mosi_sy <= {mosi_sy[SYNC_DEPTH-2:0], spi_mosi_i};
      sclk_d  <= sclk_s;
      cs_d    <= cs_sync;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt <= '0;
      rx_q    <= '0;
    end else if (!active) begin
      bit_cnt <= '0;
    end else if (sclk_rise) begin
      bit_cnt <= bit_cnt + 3'd1;
      rx_q    <= rx_byte;
    end
  end

  // preload parks the byte; its MSB goes out on the next SCLK fall
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_q   <= '0;
      miso_q <= 1'b0;
    end else if (tx_start) begin
      tx_q   <= {tx_byte[BYTE_W-2:0], 1'b0};
      miso_q <= tx_byte[BYTE_W-1];
    end else if (tx_load) begin
      tx_q   <= tx_byte;
    end else if (!active) begin
      miso_q <= 1'b0;
    end else if (sclk_fall) begin
      miso_q <= tx_q[BYTE_W-1];
      tx_q   <= {tx_q[BYTE_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/spi_slave_regbank.sv
// SPI responder with a byte-wide register bank:
// command/address/data framing, auto-increment, write notify.
module spi_slave_regbank
  import spi_slave_regbank_pkg::*;
#(
  parameter int unsigned        ADDR_W      = 4,
  parameter logic [BYTE_W-1:0]  STATUS_BYTE = 8'hA5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_sclk_i,
  input  logic              spi_cs_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  input  logic [ADDR_W-1:0] reg_addr_i,
  output logic [BYTE_W-1:0] reg_data_o,
  output logic              wr_strobe_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [BYTE_W-1:0] wr_data_o,
  output logic              busy_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nx;
  logic [BYTE_W-1:0] bank [DEPTH];

  logic              byte_done;
  logic [BYTE_W-1:0] rx_byte;
  logic              cs_fall;
  logic              cs_rise;
  logic              cs_sync;
  logic              tx_start;
  logic              tx_load;
  logic [BYTE_W-1:0] tx_byte;
  logic              we;
  logic              addr_set;
  logic              addr_inc;

  spi_slave_regbank_phy u_phy (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .spi_sclk_i (spi_sclk_i),
    .spi_cs_i   (spi_cs_i),
    .spi_mosi_i (spi_mosi_i),
    .tx_start   (tx_start),
    .tx_load    (tx_load),
    .tx_byte    (tx_byte),
    .byte_done  (byte_done),
    .rx_byte    (rx_byte),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise),
    .cs_sync    (cs_sync),
    .miso       (spi_miso_o)
  );

  assign addr_nx    = addr_q + 1'b1;
  assign reg_data_o = bank[reg_addr_i];
  assign busy_o     = (state != ST_IDLE) & ~cs_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    tx_start = 1'b0;
    tx_load  = 1'b0;
    tx_byte  = STATUS_BYTE;
    we       = 1'b0;
    addr_set = 1'b0;
    addr_inc = 1'b0;
    if (cs_rise) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            tx_start = 1'b1;
            state_n  = ST_CMD;
          end
        end
        ST_CMD: begin
          if (byte_done) begin
            addr_set = 1'b1;
            tx_load  = 1'b1;
            if (rx_byte[CMD_RW_BIT]) begin
              tx_byte = bank[rx_byte[ADDR_W-1:0]];
              state_n = ST_READ;
            end else begin
              state_n = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (byte_done) begin
            we       = 1'b1;
            addr_inc = 1'b1;
            tx_load  = 1'b1;
          end
        end
        ST_READ: begin
          if (byte_done) begin
            addr_inc = 1'b1;
            tx_load  = 1'b1;
            tx_byte  = bank[addr_nx];
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      wr_strobe_o <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else begin
      wr_strobe_o <= we;
      if (addr_set)      addr_q <= rx_byte[ADDR_W-1:0];
      else if (addr_inc) addr_q <= addr_nx;
      if (we) begin
        bank[addr_q] <= rx_byte;
        wr_addr_o    <= addr_q;
        wr_data_o    <= rx_byte;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Directed bench: bit-banged SPI master, strobe log, reset/abort cases.
// Expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_spi_slave_regbank;

  localparam int ADDR_W = 4;
  localparam int HALF   = 50;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              spi_sclk_i = 1'b0;
  logic              spi_cs_i = 1'b1;
  logic              spi_mosi_i = 1'b0;
  logic              spi_miso_o;
  logic [ADDR_W-1:0] reg_addr_i = '0;
  logic [7:0]        reg_data_o;
  logic              wr_strobe_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [7:0]        wr_data_o;
  logic              busy_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] log_addr[$];
  logic [7:0] log_data[$];
  logic [7:0] rx;
  int base;

  spi_slave_regbank #(.ADDR_W(ADDR_W), .STATUS_BYTE(8'hA5)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .spi_sclk_i  (spi_sclk_i),
    .spi_cs_i    (spi_cs_i),
    .spi_mosi_i  (spi_mosi_i),
    .spi_miso_o  (spi_miso_o),
    .reg_addr_i  (reg_addr_i),
    .reg_data_o  (reg_data_o),
    .wr_strobe_o (wr_strobe_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe_o) begin
      log_addr.push_back(wr_addr_o);
      log_data.push_back(wr_data_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits,
                          output logic [7:0] r);
    r = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi_i = tx[i];
      #HALF;
      r[i] = spi_miso_o;
      spi_sclk_i = 1'b1;
      #HALF;
      spi_sclk_i = 1'b0;
    end
  endtask

  task automatic frame_start();
    spi_cs_i = 1'b0;
    #100;
  endtask

  task automatic frame_end();
    #HALF;
    spi_cs_i = 1'b1;
    #200;
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a,
                           input logic [7:0] exp);
    reg_addr_i = a;
    #1;
    check(tag, reg_data_o, exp);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1 rst_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_miso", spi_miso_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_strobe", wr_strobe_o, 0);
    check("rst_wr_addr", wr_addr_o, 0);
    check("rst_wr_data", wr_data_o, 0);
    check_reg("rst_bank3", 4'd3, 8'h00);

    // 1: single write
    frame_start();
    spi_bits(8'h03, 8, rx);
    check("t1_miso0", rx, 8'hA5);
    check("t1_busy", busy_o, 1);
    spi_bits(8'h5C, 8, rx);
    check("t1_miso1", rx, 8'hA5);
    frame_end();
    check("t1_busy_end", busy_o, 0);
    check("t1_miso_idle", spi_miso_o, 0);
    check("t1_nstrobe", log_addr.size(), 1);
    check("t1_wr_addr", log_addr[0], 4'd3);
    check("t1_wr_data", log_data[0], 8'h5C);
    check("t1_hold_addr", wr_addr_o, 4'd3);
    check("t1_hold_data", wr_data_o, 8'h5C);
    check_reg("t1_bank3", 4'd3, 8'h5C);

    // 2: burst write wrapping 15 -> 0
    frame_start();
    spi_bits(8'h0F, 8, rx);
    spi_bits(8'h11, 8, rx);
    spi_bits(8'h22, 8, rx);
    frame_end();
    check("t2_nstrobe", log_addr.size(), 3);
    check("t2_addr_a", log_addr[1], 4'd15);
    check("t2_data_a", log_data[1], 8'h11);
    check("t2_addr_b", log_addr[2], 4'd0);
    check("t2_data_b", log_data[2], 8'h22);
    check_reg("t2_bank15", 4'd15, 8'h11);
    check_reg("t2_bank0", 4'd0, 8'h22);

    // 3: read burst with wrap
    frame_start();
    spi_bits(8'h8F, 8, rx);
    check("t3_status", rx, 8'hA5);
    spi_bits(8'h00, 8, rx);
    check("t3_rd15", rx, 8'h11);
    spi_bits(8'h00, 8, rx);
    check("t3_rd0", rx, 8'h22);
    frame_end();
    check("t3_nstrobe", log_addr.size(), 3);

    // 4: abort mid-byte
    frame_start();
    spi_bits(8'h05, 8, rx);
    spi_bits(8'hFF, 4, rx);
    frame_end();
    check("t4_nstrobe", log_addr.size(), 3);
    check_reg("t4_bank5", 4'd5, 8'h00);
    frame_start();
    spi_bits(8'h85, 8, rx);
    check("t4_status", rx, 8'hA5);
    spi_bits(8'h00, 8, rx);
    check("t4_rd5", rx, 8'h00);
    frame_end();

    // 5: reset during data byte, CS held low
    frame_start();
    spi_bits(8'h02, 8, rx);
    spi_bits(8'h77, 4, rx);
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    #1;
    check("t5_busy", busy_o, 0);
    check("t5_miso", spi_miso_o, 0);
    spi_bits(8'h70, 4, rx);
    spi_bits(8'h02, 8, rx);
    check("t5_miso_idle", rx, 8'h00);
    check("t5_busy_idle", busy_o, 0);
    frame_end();
    check("t5_nstrobe", log_addr.size(), 3);
    check_reg("t5_bank2", 4'd2, 8'h00);
    check_reg("t5_bank3_clr", 4'd3, 8'h00);
    frame_start();
    spi_bits(8'h02, 8, rx);
    check("t5_clean_st", rx, 8'hA5);
    spi_bits(8'h77, 8, rx);
    frame_end();
    check("t5_clean_n", log_addr.size(), 4);
    check("t5_clean_addr", log_addr[3], 4'd2);
    check("t5_clean_data", log_data[3], 8'h77);
    check_reg("t5_bank2_new", 4'd2, 8'h77);

    // 6: master loopback write then read
    base = log_addr.size();
    frame_start();
    spi_bits(8'h01, 8, rx);
    check("t6_w0", rx, 8'hA5);
    spi_bits(8'hAC, 8, rx);
    check("t6_w1", rx, 8'hA5);
    frame_end();
    check("t6_nstrobe", log_addr.size() - base, 1);
    check("t6_wr_data", log_data[base], 8'hAC);
    frame_start();
    spi_bits(8'h81, 8, rx);
    check("t6_r0", rx, 8'hA5);
    spi_bits(8'h00, 8, rx);
    check("t6_r1", rx, 8'hAC);
    frame_end();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
